// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Scan-state encoding and active-low segment constants shared
//                by the two-digit seven-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        S_TENS  = 2'd0,
        S_GAP1  = 2'd1,
        S_UNITS = 2'd2,
        S_GAP2  = 2'd3
    } scan_state_t;

    // Segment order is {g,f,e,d,c,b,a}, a cleared bit lights the segment
    localparam logic [6:0] C_SEG_0    = 7'h40;
    localparam logic [6:0] C_SEG_1    = 7'h79;
    localparam logic [6:0] C_SEG_2    = 7'h24;
    localparam logic [6:0] C_SEG_3    = 7'h30;
    localparam logic [6:0] C_SEG_4    = 7'h19;
    localparam logic [6:0] C_SEG_5    = 7'h12;
    localparam logic [6:0] C_SEG_6    = 7'h02;
    localparam logic [6:0] C_SEG_7    = 7'h78;
    localparam logic [6:0] C_SEG_8    = 7'h00;
    localparam logic [6:0] C_SEG_9    = 7'h10;
    localparam logic [6:0] C_SEG_DASH = 7'h3F;
    localparam logic [6:0] C_SEG_OFF  = 7'h7F;

    localparam logic [1:0] C_DIG_TENS  = 2'b01;
    localparam logic [1:0] C_DIG_UNITS = 2'b10;
    localparam logic [1:0] C_DIG_OFF   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : Digit-load/control inputs and multiplexed display outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if;

    logic [3:0] tens_in;
    logic [3:0] units_in;
    logic       load;
    logic       blink_en;
    logic       lz_blank_en;
    logic [6:0] seg_n;
    logic [1:0] dig_n;
    logic       frame_done;

    modport master (
        output tens_in, units_in, load, blink_en, lz_blank_en,
        input  seg_n, dig_n, frame_done
    );

    modport slave (
        input  tens_in, units_in, load, blink_en, lz_blank_en,
        output seg_n, dig_n, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to active-low seven-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_n_o
);

    // Non-BCD codes show a dash so datapath faults are visible on the display
    always_comb begin
        seg_n_o = C_SEG_DASH;
        case (bcd_i)
            4'd0:    seg_n_o = C_SEG_0;
            4'd1:    seg_n_o = C_SEG_1;
            4'd2:    seg_n_o = C_SEG_2;
            4'd3:    seg_n_o = C_SEG_3;
            4'd4:    seg_n_o = C_SEG_4;
            4'd5:    seg_n_o = C_SEG_5;
            4'd6:    seg_n_o = C_SEG_6;
            4'd7:    seg_n_o = C_SEG_7;
            4'd8:    seg_n_o = C_SEG_8;
            4'd9:    seg_n_o = C_SEG_9;
            default: seg_n_o = C_SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Two-digit multiplexed seven-segment driver with anti-ghost
//                gaps, leading-zero blanking and whole-display blinking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 5000,
    parameter int unsigned BLANK_CYCLES = 50,
    parameter int unsigned BLINK_DIV    = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    seg7_scan_driver_if.slave        bus
);

    localparam logic [15:0] C_SLOT_LAST  = 16'(REFRESH_DIV - 1);
    localparam logic [7:0]  C_GAP_LAST   = 8'(BLANK_CYCLES - 1);
    localparam logic [7:0]  C_BLINK_LAST = 8'(BLINK_DIV - 1);

    scan_state_t state_q, state_d;
    logic [15:0] slot_cnt_q, slot_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        phase_q, phase_d;
    logic        slot_dark_q, slot_dark_d;
    logic [3:0]  hold_tens_q, hold_units_q;
    logic [3:0]  shadow_q, shadow_d;
    logic [6:0]  seg_n_q, seg_n_d;
    logic [1:0]  dig_n_q, dig_n_d;
    logic        frame_done_q;
    logic        w_frame_end;
    logic        w_enter_tens;
    logic        w_enter_units;
    logic [6:0]  w_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_TENS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        w_frame_end = 1'b0;
        case (state_q)
            S_TENS, S_UNITS: begin
                if (slot_cnt_q == C_SLOT_LAST) begin
                    slot_cnt_d = 16'd0;
                    state_d    = (state_q == S_TENS) ? S_GAP1 : S_GAP2;
                end else begin
                    slot_cnt_d = slot_cnt_q + 16'd1;
                end
            end
            S_GAP1, S_GAP2: begin
                if (gap_cnt_q == C_GAP_LAST) begin
                    gap_cnt_d   = 8'd0;
                    state_d     = (state_q == S_GAP1) ? S_UNITS : S_TENS;
                    w_frame_end = (state_q == S_GAP2);
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = S_TENS;
        endcase
    end

    assign w_enter_tens  = (state_d == S_TENS)  && (state_q != S_TENS);
    assign w_enter_units = (state_d == S_UNITS) && (state_q != S_UNITS);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (!bus.blink_en) begin
            frame_cnt_d = 8'd0;
            phase_d     = 1'b0;
        end else if (w_frame_end) begin
            if (frame_cnt_q == C_BLINK_LAST) begin
                frame_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Digit and blink state are latched per slot so nothing changes mid-slot
    always_comb begin
        shadow_d    = shadow_q;
        slot_dark_d = slot_dark_q;
        if (w_enter_tens) begin
            shadow_d    = hold_tens_q;
            slot_dark_d = phase_d;
        end else if (w_enter_units) begin
            shadow_d    = hold_units_q;
            slot_dark_d = phase_d;
        end
    end

    bcd_to_seg7 u_dec (
        .bcd_i   (shadow_q),
        .seg_n_o (w_seg)
    );

    always_comb begin
        seg_n_d = C_SEG_OFF;
        dig_n_d = C_DIG_OFF;
        case (state_q)
            S_TENS: begin
                if (!slot_dark_q && !(bus.lz_blank_en && (shadow_q == 4'd0))) begin
                    seg_n_d = w_seg;
                    dig_n_d = C_DIG_TENS;
                end
            end
            S_UNITS: begin
                if (!slot_dark_q) begin
                    seg_n_d = w_seg;
                    dig_n_d = C_DIG_UNITS;
                end
            end
            default: begin
                seg_n_d = C_SEG_OFF;
                dig_n_d = C_DIG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= 16'd0;
            gap_cnt_q    <= 8'd0;
            frame_cnt_q  <= 8'd0;
            phase_q      <= 1'b0;
            slot_dark_q  <= 1'b0;
            hold_tens_q  <= 4'd0;
            hold_units_q <= 4'd0;
            shadow_q     <= 4'd0;
            seg_n_q      <= C_SEG_OFF;
            dig_n_q      <= C_DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            slot_dark_q  <= slot_dark_d;
            shadow_q     <= shadow_d;
            seg_n_q      <= seg_n_d;
            dig_n_q      <= dig_n_d;
            frame_done_q <= w_frame_end;
            if (bus.load) begin
                hold_tens_q  <= bus.tens_in;
                hold_units_q <= bus.units_in;
            end
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.dig_n      = dig_n_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Directed self-checking bench, 10-clock frames (4/1/4/1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1),
        .BLINK_DIV    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] dig, input logic [6:0] seg,
                           input logic fd);
        chk({tag, ".dig"}, {6'd0, bus.dig_n}, {6'd0, dig});
        chk({tag, ".seg"}, {1'b0, bus.seg_n}, {1'b0, seg});
        chk({tag, ".fd"},  {7'd0, bus.frame_done}, {7'd0, fd});
    endtask

    // Called right after a frame boundary; consumes exactly one frame
    task automatic check_frame(input string tag, input logic [1:0] tdig, input logic [6:0] tseg,
                               input logic [1:0] udig, input logic [6:0] useg);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("%s.tens%0d", tag, i), tdig, tseg, 1'b0);
        end
        tick();
        chk_out({tag, ".gap1"}, 2'b11, 7'h7F, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("%s.units%0d", tag, i), udig, useg, 1'b0);
        end
        tick();
        chk_out({tag, ".gap2"}, 2'b11, 7'h7F, 1'b1);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.frame_done !== 1'b1 && n < 40);
        chk({tag, ".wait_frame_done"}, {7'd0, bus.frame_done}, 8'd1);
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] u);
        bus.tens_in  = t;
        bus.units_in = u;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst             = 1'b1;
        bus.tens_in     = 4'd5;
        bus.units_in    = 4'd6;
        bus.load        = 1'b1;
        bus.blink_en    = 1'b0;
        bus.lz_blank_en = 1'b0;

        // Reset state, with load held high to prove it is ignored
        tick();
        tick();
        tick();
        chk_out("reset", 2'b11, 7'h7F, 1'b0);
        bus.load = 1'b0;
        rst      = 1'b0;
        check_frame("post_reset", 2'b01, 7'h40, 2'b10, 7'h40);

        do_load(4'd4, 4'd2);
        wait_frame("ld42");
        check_frame("f42a", 2'b01, 7'h19, 2'b10, 7'h24);
        check_frame("f42b", 2'b01, 7'h19, 2'b10, 7'h24);

        // Leading-zero blanking on and off
        bus.lz_blank_en = 1'b1;
        do_load(4'd0, 4'd7);
        wait_frame("ld07");
        check_frame("lz_on", 2'b11, 7'h7F, 2'b10, 7'h78);
        bus.lz_blank_en = 1'b0;
        check_frame("lz_off", 2'b01, 7'h40, 2'b10, 7'h78);

        // Non-BCD tens digit shows a dash
        do_load(4'd12, 4'd5);
        wait_frame("ld125");
        check_frame("dash", 2'b01, 7'h3F, 2'b10, 7'h12);

        // Load during the tens slot must not tear the lit digit
        do_load(4'd3, 4'd3);
        wait_frame("ld33");
        tick();
        chk_out("tear.t0", 2'b01, 7'h30, 1'b0);
        bus.tens_in  = 4'd9;
        bus.units_in = 4'd9;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        chk_out("tear.t1", 2'b01, 7'h30, 1'b0);
        tick();
        chk_out("tear.t2", 2'b01, 7'h30, 1'b0);
        tick();
        chk_out("tear.t3", 2'b01, 7'h30, 1'b0);
        tick();
        chk_out("tear.gap1", 2'b11, 7'h7F, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("tear.units%0d", i), 2'b10, 7'h10, 1'b0);
        end
        tick();
        chk_out("tear.gap2", 2'b11, 7'h7F, 1'b1);
        check_frame("tear.next", 2'b01, 7'h10, 2'b10, 7'h10);

        // Blink: two frames lit, two dark, repeating
        do_load(4'd8, 4'd8);
        wait_frame("ld88");
        bus.blink_en = 1'b1;
        check_frame("blink.lit0",  2'b01, 7'h00, 2'b10, 7'h00);
        check_frame("blink.lit1",  2'b01, 7'h00, 2'b10, 7'h00);
        check_frame("blink.dark0", 2'b11, 7'h7F, 2'b11, 7'h7F);
        check_frame("blink.dark1", 2'b11, 7'h7F, 2'b11, 7'h7F);
        check_frame("blink.lit2",  2'b01, 7'h00, 2'b10, 7'h00);
        check_frame("blink.lit3",  2'b01, 7'h00, 2'b10, 7'h00);

        // Drop blink_en inside a dark tens slot: units slot comes back lit
        tick();
        chk_out("unblink.t0", 2'b11, 7'h7F, 1'b0);
        bus.blink_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_out($sformatf("unblink.t%0d", i), 2'b11, 7'h7F, 1'b0);
        end
        tick();
        chk_out("unblink.gap1", 2'b11, 7'h7F, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("unblink.units%0d", i), 2'b10, 7'h00, 1'b0);
        end
        tick();
        chk_out("unblink.gap2", 2'b11, 7'h7F, 1'b1);

        // Asynchronous reset in the middle of the units slot
        for (int i = 0; i < 6; i++) tick();
        chk_out("pre_arst", 2'b10, 7'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("arst", 2'b11, 7'h7F, 1'b0);
        tick();
        tick();
        chk_out("arst_hold", 2'b11, 7'h7F, 1'b0);
        rst = 1'b0;
        check_frame("arst_release", 2'b01, 7'h40, 2'b10, 7'h40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 5000, sets clocks each digit is lit per scan slot (legal 2..65535).
REQ-002 Parameter BLANK_CYCLES, default 50, sets all-off anti-ghosting gap clocks between digits (legal 1..255).
REQ-003 Parameter BLINK_DIV, default 25, sets number of frames per blink half-period (legal 1..255).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tens_in  input  4  BCD tens digit from the game datapath.
REQ-007 units_in  input  4  BCD units digit from the game datapath.
REQ-008 load  input  1  single-cycle strobe; capture tens_in/units_in.
REQ-009 blink_en  input  1  level; blink the whole display (result phase).
REQ-010 lz_blank_en  input  1  level; suppress a leading zero in the tens digit.
REQ-011 seg_n  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-012 dig_n  output  2  active-low digit enables, [1]=tens, [0]=units, registered.
REQ-013 frame_done  output  1  one-cycle pulse on the last clock of each full scan frame, registered.

Function
REQ-014 The block SHALL capture tens_in/units_in into a hold register on every clock where load=1; without load the hold register is unchanged.
REQ-015 Scan FSM states: S_TENS -> S_GAP1 -> S_UNITS -> S_GAP2 -> S_TENS; S_TENS/S_UNITS last REFRESH_DIV clocks, gaps last BLANK_CYCLES clocks; frame length = 2*REFRESH_DIV + 2*BLANK_CYCLES.
REQ-016 On entry to S_TENS or S_UNITS the hold-register digit SHALL be copied to a display shadow; a load mid-slot SHALL NOT alter the digit currently lit (no tearing).
REQ-017 Decode: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; values 10..15 SHALL display dash 7'h3F.
REQ-018 In S_TENS dig_n=2'b01, in S_UNITS dig_n=2'b10, in gaps dig_n=2'b11 and seg_n=7'h7F.
REQ-019 If lz_blank_en=1 and shadow tens=0, S_TENS SHALL drive dig_n=2'b11, seg_n=7'h7F; units digit 0 is always shown.
REQ-020 Blink phase register SHALL toggle on each BLINK_DIV-th frame_done while blink_en=1; while phase=1 dig_n=2'b11, seg_n=7'h7F.
REQ-021 blink_en=0 SHALL clear phase and the frame count the next clock; display resumes next slot.
REQ-022 Blinking SHALL NOT stall the scan FSM or frame_done.
REQ-023 frame_done SHALL assert on the final clock of S_GAP2 only.
REQ-024 Slot/gap counters SHALL wrap to 0 on state change; no counter overflow at max legal parameters (16-bit slot, 8-bit gap, 8-bit frame counters).

Reset
REQ-025 While rst=1: seg_n=7'h7F, dig_n=2'b11, frame_done=0, FSM=S_TENS, all counters 0, hold/shadow registers 0, blink phase 0; load ignored.
REQ-026 After rst falls, the first rising clk edge SHALL begin counting the first S_TENS slot; assertion mid-frame SHALL blank outputs immediately (asynchronous).

Structure
REQ-027 Scan state encodings and the segment constants (digits, dash, all-off) SHALL live in a shared package seg7_pkg.
REQ-028 Decoder SHALL be one combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out); all other logic in seg7_scan_driver.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_DIV=2; frame=10 clocks)
REQ-029 Reset release, load tens=4 units=2 -> repeating: 4 clks dig_n=01 seg_n=19, 1 clk 11/7F, 4 clks dig_n=10 seg_n=24, 1 clk 11/7F; frame_done every 10th clock.
REQ-030 Load 0,7 with lz_blank_en=1 -> tens slot dig_n=11 seg_n=7F, units slot seg_n=78; lz_blank_en=0 -> tens slot seg_n=40.
REQ-031 Load 3,3 then load 9,9 on 2nd clock of S_TENS -> tens stays 7'h30 rest of slot, units slot shows 7'h10, next tens slot 7'h10.
REQ-032 Load 12,5 -> tens slot seg_n=3F (dash), units seg_n=12.
REQ-033 blink_en=1 with 8,8 -> 2 frames lit (seg_n=00), 2 frames dark (dig_n=11), repeating; drop blink_en in dark phase -> next digit slot lit.
REQ-034 Assert rst mid-S_UNITS -> seg_n=7F, dig_n=11 same cycle without clock; release -> restart S_TENS showing 0 (hold cleared).
